digit_scan_debouncer: RTL and testbench

//  Parametrised time-multiplexed scanner for the launchpad key/digit inputs.
//  - Prescaled pointer walks N_CH input lines; live Dout mirrors the selected line.
//  - Per-channel debounce plus press-event detection, which the 12-line digit selecter lacks.
//  - Sits between the raw pad inputs and the sequencer/sound logic; emits a one-cycle KEY_VALID with KEY_CODE.

---
 rtl/digit_scan_debouncer.sv | 116 +++++++++++
 tb/tb_digit_scan_debouncer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_debouncer.sv
// Time-multiplexed input scanner: a prescaled pointer walks N_CH lines, each line
// gets its own debounce counter, and a 0->1 stable transition emits KEY_VALID/KEY_CODE.
module digit_scan_debouncer #(
    parameter int N_CH = 12,
    parameter int DIV  = 3,
    parameter int DEB  = 4,
    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            HOLD,
    input  logic [N_CH-1:0] Din,
    output logic            Dout,
    output logic [CW-1:0]   SEL,
    output logic [N_CH-1:0] PRESSED,
    output logic            KEY_VALID,
    output logic [CW-1:0]   KEY_CODE
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = $clog2(DEB) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] S_LAST = CW'(N_CH - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEB - 1);

    logic [PW-1:0]   pcnt_r;
    logic [CW-1:0]   sel_r;
    logic [N_CH-1:0] pressed_r;
    logic [DW-1:0]   dcnt_r [N_CH];
    logic            key_valid_r;
    logic [CW-1:0]   key_code_r;

    logic            tick_s;
    logic            sample_s;
    logic            differ_s;
    logic            flip_s;
    logic            press_s;
    logic [DW-1:0]   dcnt_cur_s;
    logic [DW-1:0]   dcnt_next_s;
    logic [PW-1:0]   pcnt_next_s;
    logic [CW-1:0]   sel_next_s;

    // Next-state decode for the prescaler, pointer and the selected channel's debouncer
    always_comb begin
        tick_s      = EN && (pcnt_r == P_LAST);
        sample_s    = Din[sel_r];
        dcnt_cur_s  = dcnt_r[sel_r];
        differ_s    = (sample_s != pressed_r[sel_r]);
        flip_s      = 1'b0;
        dcnt_next_s = {DW{1'b0}};
        pcnt_next_s = pcnt_r;
        sel_next_s  = sel_r;

        // A matching sample cancels any partial count, so short glitches leave no trace
        if (!differ_s) begin
            dcnt_next_s = {DW{1'b0}};
        end else if (dcnt_cur_s == D_LAST) begin
            flip_s      = 1'b1;
            dcnt_next_s = {DW{1'b0}};
        end else begin
            dcnt_next_s = dcnt_cur_s + DW'(1);
        end
        press_s = tick_s && flip_s && sample_s;

        if (tick_s) begin
            pcnt_next_s = {PW{1'b0}};
        end else if (EN) begin
            pcnt_next_s = pcnt_r + PW'(1);
        end else begin
            pcnt_next_s = pcnt_r;
        end

        if (!tick_s || HOLD) begin
            sel_next_s = sel_r;
        end else if (sel_r == S_LAST) begin
            sel_next_s = {CW{1'b0}};
        end else begin
            sel_next_s = sel_r + CW'(1);
        end
    end

    // State registers: prescaler, pointer, per-channel debounce and event outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pcnt_r      <= {PW{1'b0}};
            sel_r       <= {CW{1'b0}};
            pressed_r   <= {N_CH{1'b0}};
            key_valid_r <= 1'b0;
            key_code_r  <= {CW{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                dcnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            pcnt_r      <= pcnt_next_s;
            sel_r       <= sel_next_s;
            key_valid_r <= press_s;
            if (press_s) begin
                key_code_r <= sel_r;
            end
            if (tick_s) begin
                dcnt_r[sel_r] <= dcnt_next_s;
                if (flip_s) begin
                    pressed_r[sel_r] <= sample_s;
                end
            end
        end
    end

    assign Dout      = Din[sel_r];
    assign SEL       = sel_r;
    assign PRESSED   = pressed_r;
    assign KEY_VALID = key_valid_r;
    assign KEY_CODE  = key_code_r;

endmodule

// File: tb/tb_digit_scan_debouncer.sv
// Scoreboard bench for digit_scan_debouncer: a visit-counting reference model
// queues expected key events; a negedge monitor pops and compares.
module tb_digit_scan_debouncer;

    localparam int N  = 12;
    localparam int DV = 3;
    localparam int DB = 4;
    localparam int CW = $clog2(N);

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          EN = 1'b1;
    logic          HOLD = 1'b0;
    logic [N-1:0]  Din = '0;
    logic          Dout;
    logic [CW-1:0] SEL;
    logic [N-1:0]  PRESSED;
    logic          KEY_VALID;
    logic [CW-1:0] KEY_CODE;

    digit_scan_debouncer #(.N_CH(N), .DIV(DV), .DEB(DB)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .HOLD(HOLD), .Din(Din),
        .Dout(Dout), .SEL(SEL), .PRESSED(PRESSED),
        .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // reference model: scan position and per-line run of disagreeing visits
    int           m_pcnt;
    int           m_sel;
    int           m_run [N];
    logic [N-1:0] m_stable;
    int           m_last_code;
    int           exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pcnt = 0;
        m_sel = 0;
        m_stable = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_last_code = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int k;
        logic s;
        if (!EN) return;
        if (m_pcnt == DV - 1) begin
            k = m_sel;
            s = Din[k];
            if (s == m_stable[k]) begin
                m_run[k] = 0;
            end else begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == DB) begin
                    m_stable[k] = s;
                    m_run[k] = 0;
                    if (s) begin
                        exp_q.push_back(k);
                        m_last_code = k;
                    end
                end
            end
            if (!HOLD) m_sel = (m_sel + 1) % N;
        end
        m_pcnt = (m_pcnt + 1) % DV;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) model_reset();
            else model_step();
        end
    end

    // monitor: compares on falling edge, pops one expectation per presented pulse
    initial begin
        int code;
        forever begin
            @(negedge CLK);
            chk("sel", 32'(SEL), 32'(m_sel));
            chk("pressed", 32'(PRESSED), 32'(m_stable));
            chk("dout", 32'(Dout), 32'(Din[m_sel]));
            if (KEY_VALID === 1'b1) pulses++;
            if (exp_q.size() > 0) begin
                code = exp_q.pop_front();
                chk("key_valid", 32'(KEY_VALID), 32'd1);
                chk("key_code_evt", 32'(KEY_CODE), 32'(code));
            end else begin
                chk("key_valid_idle", 32'(KEY_VALID), 32'd0);
            end
            chk("key_code_hold", 32'(KEY_CODE), 32'(m_last_code));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    initial begin
        int b;
        // reset held with all lines active
        Din = '1;
        RST = 1'b0;
        cyc(6);
        // ch7 held from reset release
        Din = '0;
        Din[7] = 1'b1;
        RST = 1'b1;
        cyc(200);
        chk("press7_state", 32'(PRESSED[7]), 32'd1);
        chk("press7_code", 32'(KEY_CODE), 32'd7);
        chk("press7_pulses", 32'(pulses), 32'd1);
        // Dout follows ch5 forced only while it is selected
        for (int i = 0; i < 72; i++) begin
            Din[5] = (m_sel == 5);
            cyc(1);
        end
        Din[5] = 1'b0;
        // bounce: exactly three ch2 visits at 1
        Din[2] = 1'b1;
        cyc(3 * N * DV);
        Din[2] = 1'b0;
        cyc(80);
        chk("bounce2_state", 32'(PRESSED[2]), 32'd0);
        chk("bounce2_pulses", 32'(pulses), 32'd1);
        // release of ch7: state drops, no pulse
        Din[7] = 1'b0;
        cyc(200);
        chk("release7_state", 32'(PRESSED[7]), 32'd0);
        chk("release7_pulses", 32'(pulses), 32'd1);
        // HOLD parked on ch4
        b = 0;
        while (m_sel != 4 && b < 100) begin
            cyc(1);
            b++;
        end
        chk("reach_sel4", 32'(m_sel), 32'd4);
        HOLD = 1'b1;
        Din[4] = 1'b1;
        cyc(20);
        chk("hold4_pulses", 32'(pulses), 32'd2);
        chk("hold4_code", 32'(KEY_CODE), 32'd4);
        chk("hold4_sel", 32'(SEL), 32'd4);
        // freeze
        EN = 1'b0;
        Din[4] = 1'b0;
        cyc(20);
        chk("freeze_state", 32'(PRESSED[4]), 32'd1);
        EN = 1'b1;
        HOLD = 1'b0;
        cyc(40);
        // randomized traffic with occasional async reset mid-cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) Din[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) HOLD = ~HOLD;
            EN = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 599) == 0) begin
                #1 RST = 1'b0;
                cyc(2);
                RST = 1'b1;
            end
            cyc(1);
        end
        cyc(2);
        chk("leftover_events", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
